// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// controller state encoding and the alignment rule used to reject requests.
package lsu_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } lsu_state_t;

   // A request is rejected when its size is reserved or its byte lane does
   // not match the natural alignment of the access size.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = lane[0];
         SIZE_WORD: bad = (lane != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-lane steering for the load/store unit. Purely combinational.
// Produces the word to write back for a store (sub-word data merged into the
// previously read word, little-endian lanes) and the extracted, sign- or
// zero-extended value for a load. Word accesses pass straight through.
import lsu_pkg::*;

module lsu_lane_merge (
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   input  logic        is_unsigned,
   output logic [31:0] merged,
   output logic [31:0] loaded
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Lane selection, store merge and load extension in one pass
   always_comb begin
      merged   = word;
      loaded   = word;
      sel_byte = word[7:0];
      sel_half = lane[1] ? word[31:16] : word[15:0];
      case (lane)
         2'd0: sel_byte = word[7:0];
         2'd1: sel_byte = word[15:8];
         2'd2: sel_byte = word[23:16];
         default: sel_byte = word[31:24];
      endcase
      case (size)
         SIZE_BYTE: begin
            case (lane)
               2'd0: merged[7:0]   = wdata[7:0];
               2'd1: merged[15:8]  = wdata[7:0];
               2'd2: merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
            loaded = is_unsigned ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
         end
         SIZE_HALF: begin
            if (lane[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
            loaded = is_unsigned ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
         end
         default: begin
            merged = wdata;
            loaded = word;
         end
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the core and a word-addressed data memory.
// Accepts one request at a time in IDLE, reads the target word when a load
// or a sub-word store needs it, writes the (merged) word back, and returns a
// one-cycle response pulse with data or an error flag.
// Optional build macro LSU_BOUNDS_CHECK_EN: reject requests whose byte
// address has bits set above the memory range instead of wrapping.
import lsu_pkg::*;

module lsu_mem_ctrl #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_wd,
   output logic              mem_we,
   input  logic [31:0]       mem_rd
);

   lsu_state_t        state, state_next;
   logic              lat_we, lat_unsigned, lat_err;
   logic [1:0]        lat_size, lat_lane;
   logic [31:0]       lat_wdata, held_word;
   logic [ADDR_W-1:0] lat_index;
   logic              req_err;
   logic [31:0]       merged_word, loaded_word;

   assign mem_address = lat_index;

   // Decide in IDLE whether the incoming request must be rejected
   always_comb begin
      req_err = misaligned(req_size, req_addr[1:0]);
`ifdef LSU_BOUNDS_CHECK_EN
      if ((req_addr >> (ADDR_W + 2)) != 32'd0) req_err = 1'b1;
`endif
   end

   // State register; reset abandons any in-flight request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Capture the request on acceptance and the memory word during READ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we       <= 1'b0;
         lat_unsigned <= 1'b0;
         lat_err      <= 1'b0;
         lat_size     <= SIZE_BYTE;
         lat_lane     <= 2'd0;
         lat_wdata    <= 32'd0;
         lat_index    <= '0;
         held_word    <= 32'd0;
      end else begin
         if (state == IDLE && req_valid) begin
            lat_we       <= req_we;
            lat_unsigned <= req_unsigned;
            lat_err      <= req_err;
            lat_size     <= req_size;
            lat_lane     <= req_addr[1:0];
            lat_wdata    <= req_wdata;
            lat_index    <= req_addr[ADDR_W+1:2];
         end
         if (state == READ) held_word <= mem_rd;
      end
   end

   lsu_lane_merge u_lane_merge (
      .word        (held_word),
      .lane        (lat_lane),
      .size        (lat_size),
      .wdata       (lat_wdata),
      .is_unsigned (lat_unsigned),
      .merged      (merged_word),
      .loaded      (loaded_word)
   );

   // Next-state selection and per-state outputs
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      resp_err   = 1'b0;
      mem_we     = 1'b0;
      mem_wd     = 32'd0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err)                  state_next = RESP;
               else if (!req_we)             state_next = READ;
               else if (req_size == SIZE_WORD) state_next = WRITE;
               else                          state_next = READ;
            end
         end
         READ: begin
            state_next = lat_we ? WRITE : RESP;
         end
         WRITE: begin
            mem_we     = 1'b1;
            mem_wd     = merged_word;
            state_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = lat_err;
            resp_rdata = (lat_err || lat_we) ? 32'd0 : loaded_word;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl. A behavioural memory sits on the
// memory port; a reference model computes expected responses and memory
// contents from plain byte/halfword arithmetic on a shadow array.
// Honours LSU_BOUNDS_CHECK_EN if the design is built with it.
module tb_lsu_mem_ctrl;

   localparam int ADDR_W = 5;
   localparam int unsigned DEPTH = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [31:0]       req_addr = 32'd0;
   logic [1:0]        req_size = 2'd0;
   logic              req_unsigned = 1'b0;
   logic [31:0]       req_wdata = 32'd0;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_wd;
   logic              mem_we;
   logic [31:0]       mem_rd;

   logic [31:0] mem     [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];
   logic              preload_en = 1'b0;
   logic [ADDR_W-1:0] preload_idx = '0;
   logic [31:0]       preload_data = 32'd0;

   int errors = 0;
   int checks = 0;

   // Captured results of the last issued request
   logic              res_got, res_after_valid, res_busy_ready;
   int                res_lat, res_pulses, res_we_at;
   logic [31:0]       res_rdata, res_wd;
   logic              res_err;
   logic [ADDR_W-1:0] res_waddr;

   // Model expectations for the last modelled request
   logic              exp_err;
   int                exp_lat, exp_pulses;
   logic [31:0]       exp_rdata, exp_wd;
   logic [ADDR_W-1:0] exp_idx;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_address  (mem_address),
      .mem_wd       (mem_wd),
      .mem_we       (mem_we),
      .mem_rd       (mem_rd)
   );

   assign mem_rd = mem[mem_address];

   always @(posedge clk) begin
      if (mem_we) mem[mem_address] <= mem_wd;
      else if (preload_en) mem[preload_idx] <= preload_data;
   end

   function automatic logic [31:0] model_load(input logic [31:0] w, input int unsigned lane,
                                              input logic [1:0] size, input logic uns);
      logic [31:0] v;
      if (size == 2'd0) begin
         v = (w >> (8 * lane)) & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
         v = (w >> (8 * lane)) & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   task automatic model_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] wdata);
      int unsigned lane, idx;
      logic [31:0] mask, old_word;
      lane = addr % 4;
      idx  = (addr / 4) % DEPTH;
      exp_idx = idx[ADDR_W-1:0];
      exp_err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && lane != 0);
`ifdef LSU_BOUNDS_CHECK_EN
      if (addr >= 4 * DEPTH) exp_err = 1'b1;
`endif
      old_word  = ref_mem[idx];
      exp_rdata = 32'd0;
      exp_wd    = 32'd0;
      exp_pulses = 0;
      if (exp_err) exp_lat = 1;
      else if (!we || size == 2'd2) exp_lat = 2;
      else exp_lat = 3;
      if (!exp_err) begin
         if (we) begin
            if (size == 2'd2) begin
               exp_wd = wdata;
            end else begin
               mask = ((size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * lane);
               exp_wd = (old_word & ~mask) | ((wdata << (8 * lane)) & mask);
            end
            exp_pulses = 1;
            ref_mem[idx] = exp_wd;
         end else begin
            exp_rdata = model_load(old_word, lane, size, uns);
         end
      end
   endtask

   task automatic preload(input int unsigned idx, input logic [31:0] data);
      @(negedge clk);
      preload_en   = 1'b1;
      preload_idx  = idx[ADDR_W-1:0];
      preload_data = data;
      @(posedge clk);
      #1 preload_en = 1'b0;
      ref_mem[idx] = data;
   endtask

   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr;
      req_size = size; req_unsigned = uns; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = $urandom; req_addr = $urandom;
      req_size = 2'($urandom); req_unsigned = $urandom; req_wdata = $urandom;
      res_lat = 0; res_got = 1'b0; res_pulses = 0; res_we_at = 0; res_busy_ready = 1'b0;
      res_rdata = 32'd0; res_err = 1'b0; res_wd = 32'd0; res_waddr = '0;
      while (!res_got && res_lat < 8) begin
         @(negedge clk);
         res_lat++;
         if (mem_we) begin
            res_pulses++; res_we_at = res_lat; res_wd = mem_wd; res_waddr = mem_address;
         end
         if (resp_valid) begin
            res_got = 1'b1; res_rdata = resp_rdata; res_err = resp_err;
         end else if (req_ready) begin
            res_busy_ready = 1'b1;
         end
      end
      @(negedge clk);
      res_after_valid = resp_valid;
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #2;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b want=1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got=%b want=0", resp_valid); end
      checks++; if (resp_rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata got=%h want=0", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b want=0", resp_err); end
      checks++; if (mem_address !== '0) begin errors++; $display("[TB] FAIL reset_mem_address got=%h want=0", mem_address); end
      checks++; if (mem_wd !== 32'd0) begin errors++; $display("[TB] FAIL reset_mem_wd got=%h want=0", mem_wd); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we got=%b want=0", mem_we); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) preload(i, $urandom);
   endtask

   task automatic test_sign_extend;
      preload(3, 32'h8899_AABB);
      applyStimulus(1'b0, 32'h0000_000F, 2'd0, 1'b0, 32'd0);
      checks++; if (!res_got || res_lat != 2) begin errors++; $display("[TB] FAIL lb_signed_latency got=%0d want=2", res_lat); end
      checks++; if (res_rdata !== 32'hFFFF_FF88) begin errors++; $display("[TB] FAIL lb_signed_rdata got=%h want=ffffff88", res_rdata); end
      checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL lb_signed_err got=%b want=0", res_err); end
      applyStimulus(1'b0, 32'h0000_000F, 2'd0, 1'b1, 32'd0);
      checks++; if (res_rdata !== 32'h0000_0088) begin errors++; $display("[TB] FAIL lb_unsigned_rdata got=%h want=00000088", res_rdata); end
      applyStimulus(1'b0, 32'h0000_000C, 2'd1, 1'b0, 32'd0);
      checks++; if (res_rdata !== 32'hFFFF_AABB) begin errors++; $display("[TB] FAIL lh_signed_rdata got=%h want=ffffaabb", res_rdata); end
   endtask

   task automatic test_word_store;
      model_req(1'b1, 32'h0000_0008, 2'd2, 1'b0, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 32'h0000_0008, 2'd2, 1'b0, 32'hDEAD_BEEF);
      checks++; if (res_pulses != 1 || res_we_at != 1) begin errors++; $display("[TB] FAIL sw_we_pulse got=%0d@%0d want=1@1", res_pulses, res_we_at); end
      checks++; if (res_waddr !== 5'd2) begin errors++; $display("[TB] FAIL sw_address got=%0d want=2", res_waddr); end
      checks++; if (res_wd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sw_wd got=%h want=deadbeef", res_wd); end
      checks++; if (!res_got || res_lat != 2 || res_rdata !== 32'd0) begin errors++; $display("[TB] FAIL sw_resp got=%0d/%h want=2/0", res_lat, res_rdata); end
      applyStimulus(1'b0, 32'h0000_0008, 2'd2, 1'b0, 32'd0);
      checks++; if (res_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL lw_after_sw got=%h want=deadbeef", res_rdata); end
   endtask

   task automatic test_half_store;
      logic [31:0] snap [0:DEPTH-1];
      preload(1, 32'h1122_3344);
      for (int i = 0; i < int'(DEPTH); i++) snap[i] = mem[i];
      model_req(1'b1, 32'h0000_0006, 2'd1, 1'b0, 32'h1234_CAFE);
      applyStimulus(1'b1, 32'h0000_0006, 2'd1, 1'b0, 32'h1234_CAFE);
      checks++; if (res_wd !== 32'hCAFE_3344) begin errors++; $display("[TB] FAIL sh_wd got=%h want=cafe3344", res_wd); end
      checks++; if (!res_got || res_lat != 3) begin errors++; $display("[TB] FAIL sh_latency got=%0d want=3", res_lat); end
      checks++; if (mem[1] !== 32'hCAFE_3344) begin errors++; $display("[TB] FAIL sh_word1 got=%h want=cafe3344", mem[1]); end
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (i != 1) begin
            checks++;
            if (mem[i] !== snap[i]) begin errors++; $display("[TB] FAIL sh_untouched[%0d] got=%h want=%h", i, mem[i], snap[i]); end
         end
      end
   endtask

   task automatic test_misaligned;
      applyStimulus(1'b0, 32'h0000_0005, 2'd1, 1'b0, 32'd0);
      checks++; if (!res_got || res_lat != 1 || res_err !== 1'b1) begin errors++; $display("[TB] FAIL lh_misaligned got=%0d/%b want=1/1", res_lat, res_err); end
      checks++; if (res_rdata !== 32'd0 || res_pulses != 0) begin errors++; $display("[TB] FAIL lh_misaligned_side got=%h/%0d want=0/0", res_rdata, res_pulses); end
      applyStimulus(1'b1, 32'h0000_0002, 2'd2, 1'b0, 32'h5555_AAAA);
      checks++; if (!res_got || res_lat != 1 || res_err !== 1'b1) begin errors++; $display("[TB] FAIL sw_misaligned got=%0d/%b want=1/1", res_lat, res_err); end
      checks++; if (res_pulses != 0 || res_rdata !== 32'd0) begin errors++; $display("[TB] FAIL sw_misaligned_side got=%0d/%h want=0/0", res_pulses, res_rdata); end
      applyStimulus(1'b1, 32'h0000_0010, 2'd3, 1'b0, 32'h0);
      checks++; if (res_err !== 1'b1 || res_pulses != 0) begin errors++; $display("[TB] FAIL size_reserved got=%b/%0d want=1/0", res_err, res_pulses); end
   endtask

   task automatic test_reset_mid_write;
      logic seen, rv;
      int n;
      preload(4, 32'h0102_0304);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0011;
      req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0000_00A5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      seen = 1'b0; n = 0;
      while (!seen && n < 6) begin
         @(negedge clk); n++;
         if (mem_we) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("[TB] FAIL rst_write_reached got=0 want=1"); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_we_async got=%b want=0", mem_we); end
      rv = 1'b0;
      repeat (2) begin @(posedge clk); #1 if (resp_valid) rv = 1'b1; end
      @(negedge clk) rst_n = 1'b1;
      repeat (4) begin @(negedge clk); if (resp_valid) rv = 1'b1; end
      checks++; if (rv !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_resp got=1 want=0"); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got=%b want=1", req_ready); end
      checks++; if (mem[4] !== 32'h0102_0304) begin errors++; $display("[TB] FAIL rst_word_kept got=%h want=01020304", mem[4]); end
   endtask

   task automatic test_wrap;
      preload(1, 32'h5566_7788);
      applyStimulus(1'b0, 32'h0000_0084, 2'd2, 1'b0, 32'd0);
`ifdef LSU_BOUNDS_CHECK_EN
      checks++; if (!res_got || res_lat != 1 || res_err !== 1'b1) begin errors++; $display("[TB] FAIL bounds_load got=%0d/%b want=1/1", res_lat, res_err); end
      checks++; if (res_rdata !== 32'd0) begin errors++; $display("[TB] FAIL bounds_rdata got=%h want=0", res_rdata); end
`else
      checks++; if (!res_got || res_lat != 2 || res_err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_load got=%0d/%b want=2/0", res_lat, res_err); end
      checks++; if (res_rdata !== 32'h5566_7788) begin errors++; $display("[TB] FAIL wrap_rdata got=%h want=55667788", res_rdata); end
`endif
      model_req(1'b1, 32'h0000_0084, 2'd0, 1'b0, 32'h0000_0011);
      applyStimulus(1'b1, 32'h0000_0084, 2'd0, 1'b0, 32'h0000_0011);
      checks++; if (res_pulses != exp_pulses || (exp_pulses == 1 && res_waddr !== 5'd1)) begin
         errors++; $display("[TB] FAIL wrap_store got=%0d@%0d want=%0d@1", res_pulses, res_waddr, exp_pulses);
      end
   endtask

   task automatic test_random;
      logic        we, uns;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
      for (int t = 0; t < 80; t++) begin
         we = $urandom; uns = $urandom; wdata = $urandom;
         size = 2'($urandom);
         if ($urandom_range(3, 0) != 0 && size == 2'd3) size = 2'($urandom_range(2, 0));
         addr = $urandom_range(127, 0);
         if ($urandom_range(7, 0) == 0) addr = addr | ($urandom << 7);
         model_req(we, addr, size, uns, wdata);
         applyStimulus(we, addr, size, uns, wdata);
         checks++; if (!res_got || res_lat != exp_lat) begin errors++; $display("[TB] FAIL rnd%0d_latency got=%0d want=%0d", t, res_lat, exp_lat); end
         checks++; if (res_err !== exp_err) begin errors++; $display("[TB] FAIL rnd%0d_err got=%b want=%b", t, res_err, exp_err); end
         checks++; if (res_rdata !== exp_rdata) begin errors++; $display("[TB] FAIL rnd%0d_rdata got=%h want=%h", t, res_rdata, exp_rdata); end
         checks++; if (res_pulses != exp_pulses) begin errors++; $display("[TB] FAIL rnd%0d_we_pulses got=%0d want=%0d", t, res_pulses, exp_pulses); end
         checks++; if (res_busy_ready || res_after_valid) begin errors++; $display("[TB] FAIL rnd%0d_handshake got=%b/%b want=0/0", t, res_busy_ready, res_after_valid); end
         if (exp_pulses == 1) begin
            checks++;
            if (res_wd !== exp_wd || res_waddr !== exp_idx) begin
               errors++; $display("[TB] FAIL rnd%0d_write got=%h@%0d want=%h@%0d", t, res_wd, res_waddr, exp_wd, exp_idx);
            end
         end
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         checks++;
         if (mem[i] !== ref_mem[i]) begin errors++; $display("[TB] FAIL rnd_mem[%0d] got=%h want=%h", i, mem[i], ref_mem[i]); end
      end
   endtask

   initial begin
      test_reset;
      test_sign_extend;
      test_word_store;
      test_half_store;
      test_misaligned;
      test_reset_mid_write;
      test_wrap;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired before the bench completed");
      $fatal(1, "[TB] timeout");
   end

endmodule
